// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: loads a binary value, converts it to BCD with a
// sequential shift-add-3 engine and time-multiplexes the committed digits
// onto one-hot digit enables driven by a refresh divider.
module display_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int IN_WIDTH = 12,
  parameter int TICK_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 load,
  input  logic [IN_WIDTH-1:0]                                  value,
  output logic                                                 busy,
  output logic [N_DIGITS-1:0]                                  en,
  output logic [3:0]                                           digit,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0]   slot,
  output logic                                                 overflow
);

  localparam int SLOT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BCD_W  = 4 * N_DIGITS;
  localparam int SR_W   = BCD_W + IN_WIDTH;
  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int CNT_W  = $clog2(IN_WIDTH + 1);

  // Largest value the digits can show: 10^N_DIGITS - 1.
  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10_m1(N_DIGITS);
  localparam logic [BCD_W-1:0] NINES = {N_DIGITS{4'h9}};

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < N_DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t             state;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_adj;
  logic [CNT_W-1:0]   step;
  logic               ovf_pend;
  logic [BCD_W-1:0]   disp;
  logic [BCD_W-1:0]   disp_nxt;

  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   div_nxt;
  logic [SLOT_W-1:0]  slot_nxt;
  logic [3:0]         digit_nxt;
  logic [N_DIGITS-1:0] en_nxt;
  logic               nz_above;
  logic               blank;

  // Add-3 correction applied to the BCD field ahead of each shift.
  always_comb begin
    sr_adj = {add3(sr[SR_W-1 -: BCD_W]), sr[IN_WIDTH-1:0]};
  end

  // Display register contents after this edge; COMMIT is the only writer.
  always_comb begin
    disp_nxt = disp;
    if (state == S_COMMIT) disp_nxt = ovf_pend ? NINES : sr[SR_W-1 -: BCD_W];
  end

  // Conversion FSM: capture, IN_WIDTH shift steps, then commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sr       <= '0;
      step     <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      disp <= disp_nxt;
      case (state)
        S_IDLE: begin
          if (load) begin
            sr       <= {{BCD_W{1'b0}}, value};
            step     <= '0;
            ovf_pend <= (64'(value) > MAX_VAL);
            busy     <= 1'b1;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          sr   <= {sr_adj[SR_W-2:0], 1'b0};
          step <= step + 1'b1;
          if (step == CNT_W'(IN_WIDTH - 1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          overflow <= ovf_pend;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Next divider / slot position of the refresh scan.
  always_comb begin
    div_nxt  = div + 1'b1;
    slot_nxt = slot;
    if (div == DIV_W'(TICK_DIV - 1)) begin
      div_nxt  = '0;
      slot_nxt = (slot == SLOT_W'(N_DIGITS - 1)) ? '0 : slot + 1'b1;
    end
  end

  // Digit, blanking and one-hot enable for the next slot and display value.
  always_comb begin
    digit_nxt = 4'd0;
    nz_above  = 1'b0;
    en_nxt    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (SLOT_W'(i) == slot_nxt) digit_nxt = disp_nxt[4*i +: 4];
      if (SLOT_W'(i) >= slot_nxt && disp_nxt[4*i +: 4] != 4'd0) nz_above = 1'b1;
    end
    blank = (BLANK_LZ != 0) && (slot_nxt != '0) && !nz_above;
    for (int i = 0; i < N_DIGITS; i++)
      en_nxt[i] = (SLOT_W'(i) == slot_nxt) && !blank;
  end

  // Scan registers: divider, slot and the registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      slot  <= '0;
      digit <= 4'd0;
      en    <= N_DIGITS'(1);
    end else begin
      div   <= div_nxt;
      slot  <= slot_nxt;
      digit <= digit_nxt;
      en    <= en_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed and random loads against a behavioural
// model of the display (decimal arithmetic on the committed value).
module tb_display_scan_ctrl;

  localparam int ND = 3;
  localparam int IW = 10;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [IW-1:0] value;

  logic          busy, busy_nb;
  logic [ND-1:0] en, en_nb;
  logic [3:0]    digit, digit_nb;
  logic [1:0]    slot, slot_nb;
  logic          overflow, overflow_nb;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_sc   = 0;   // edges since reset
  int m_busy = 0;   // remaining busy cycles
  int m_pend = 0;   // value captured by the conversion in flight
  int m_val  = 0;   // committed value

  always #5 clk = ~clk;

  display_scan_ctrl #(.N_DIGITS(ND), .IN_WIDTH(IW), .TICK_DIV(TD), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy), .en(en), .digit(digit), .slot(slot), .overflow(overflow)
  );

  display_scan_ctrl #(.N_DIGITS(ND), .IN_WIDTH(IW), .TICK_DIV(TD), .BLANK_LZ(0)) u_dut_nb (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy_nb), .en(en_nb), .digit(digit_nb), .slot(slot_nb), .overflow(overflow_nb)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic l, input int v, input logic r);
    if (r) begin
      m_sc = 0; m_busy = 0; m_val = 0; m_pend = 0;
    end else begin
      m_sc++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_val = m_pend;
      end else if (l) begin
        m_pend = v;
        m_busy = IW + 1;
      end
    end
  endtask

  task automatic check_all();
    int s, ov, dv, p10, dg, bl, en_e;
    s   = (m_sc / TD) % ND;
    ov  = (m_val > 999) ? 1 : 0;
    dv  = ov ? 999 : m_val;
    p10 = 1;
    for (int i = 0; i < s; i++) p10 = p10 * 10;
    dg   = (dv / p10) % 10;
    bl   = (s > 0 && (dv / p10) == 0) ? 1 : 0;
    en_e = bl ? 0 : (1 << s);
    chk("busy",     32'(busy),     32'(m_busy > 0));
    chk("slot",     32'(slot),     32'(s));
    chk("digit",    32'(digit),    32'(dg));
    chk("en",       32'(en),       32'(en_e));
    chk("overflow", 32'(overflow), 32'(ov));
    chk("en_noblank",    32'(en_nb),    32'(1 << s));
    chk("digit_noblank", 32'(digit_nb), 32'(dg));
    chk("busy_noblank",  32'(busy_nb),  32'(m_busy > 0));
  endtask

  task automatic cyc(input logic l, input int v, input logic r);
    load  = l;
    value = IW'(v);
    rst   = r;
    @(posedge clk);
    model_step(l, v, r);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  task automatic do_load(input int v);
    cyc(1'b1, v, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0;
    // Reset and idle scan with slots 1, 2 blanked
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);
    idle(26);
    // Basic conversion
    do_load(245);
    idle(30);
    // Blanking
    do_load(7);
    idle(26);
    do_load(0);
    idle(26);
    do_load(40);
    idle(26);
    // Overflow and the largest legal value
    do_load(1000);
    idle(26);
    do_load(999);
    idle(26);
    do_load(1023);
    idle(26);
    // Load while busy is ignored
    do_load(245);
    idle(2);
    do_load(512);
    idle(20);
    do_load(512);
    idle(26);
    // Back-to-back: load in first idle cycle after commit
    do_load(123);
    idle(IW + 1);
    do_load(806);
    idle(26);
    // Reset mid-conversion
    do_load(245);
    idle(4);
    cyc(1'b0, 0, 1'b1);
    idle(30);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int v;
      logic l, r;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 15);
        1:       v = $urandom_range(990, 1023);
        default: v = $urandom_range(0, 1023);
      endcase
      l = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 199) == 0);
      cyc(l, v, r);
    end
    idle(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
